jt6295_cengen: RTL and testbench



---
 rtl/jt6295_cengen.sv | 166 ++++++++++++++++
 tb/tb_jt6295_cengen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jt6295_cengen.sv
// jt6295_cengen - clock-enable generator for the ADPCM sample pipeline.
//
// Derives every enable used by the channel sequencer, the decoder and the
// output filter from the 1 MHz base enable `cen`. A frame is SLOTS slots,
// and each slot is DIV_LO or DIV_HI `cen` ticks long. `ss` chooses between
// the two dividers. A new `ss` value is taken up only on the last tick of a
// frame, so the frame that is running is never cut short or stretched.
//
// Optional feature: define JT6295_CENGEN_SYNC_EN to add the `sync` input.
// It restarts the frame. When the macro is undefined the frame free-runs.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active high
//   cen      in   base enable (nominally 1 MHz)
//   ss       in   rate select: 0 = DIV_LO, 1 = DIV_HI
//   sync     in   frame restart (only with JT6295_CENGEN_SYNC_EN)
//   cen_sr   out  one pulse per frame (sample rate)
//   cen_ph   out  PHASES strobes, cen_ph[k] at slot k*ACTIVE/PHASES
//   cen_slot out  pulse at each active slot (slot < ACTIVE)
//   slot_idx out  slot flagged by the most recent slot-start tick
//   cen_frac out  fractional enable at FN/FD of the `cen` rate
//
// Every pulse output is registered. It is decided from the state before the
// `cen` update and appears on the next clk cycle, for one cycle only.
//
// State of the frame timing (one implicit FSM, encoded by the counters):
//   state            | meaning
//   base_q==0        | first tick of slot slot_q, slot pulses are issued
//   base_q in 1..lim | remaining ticks of the slot
//   base_q==lim &&   | last tick of the frame; div_act_q takes up ss
//     slot_q==SLOTS-1|
module jt6295_cengen #(
  parameter int DIV_LO = 5,
  parameter int DIV_HI = 4,
  parameter int SLOTS  = 33,
  parameter int ACTIVE = 32,
  parameter int PHASES = 4,
  parameter int FN     = 6,
  parameter int FD     = 125,
  parameter int FW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              ss,
`ifdef JT6295_CENGEN_SYNC_EN
  input  logic              sync,
`endif
  output logic              cen_sr,
  output logic [PHASES-1:0] cen_ph,
  output logic              cen_slot,
  output logic [5:0]        slot_idx,
  output logic              cen_frac
);

  localparam logic [2:0]    LIM_LO    = 3'(DIV_LO - 1);
  localparam logic [2:0]    LIM_HI    = 3'(DIV_HI - 1);
  localparam logic [5:0]    SLOT_LAST = 6'(SLOTS - 1);
  localparam logic [6:0]    ACTIVE_W  = 7'(ACTIVE);
  localparam logic [FW-1:0] FN_W      = FW'(FN);
  localparam logic [FW-1:0] FD_W      = FW'(FD);

  logic [2:0]        base_q, base_d;
  logic [5:0]        slot_q, slot_d;
  logic              div_act_q, div_act_d;
  logic [FW-1:0]     acc_q, acc_d;

  logic              sr_q, sr_d;
  logic [PHASES-1:0] ph_q, ph_d;
  logic              slot_p_q, slot_p_d;
  logic [5:0]        idx_q, idx_d;
  logic              frac_q, frac_d;

  logic [2:0]        lim;
  logic              base_end;
  logic              base_zero;
  logic              frame_end;
  logic [FW-1:0]     acc_sum;

  always_comb begin
    lim       = div_act_q ? LIM_HI : LIM_LO;
    base_end  = (base_q == lim);
    base_zero = (base_q == 3'd0);
    frame_end = base_end && (slot_q == SLOT_LAST);
    // Sized to FW bits: acc_q stays below FD, so the sum stays below FD+FN.
    acc_sum   = acc_q + FN_W;

    base_d    = base_q;
    slot_d    = slot_q;
    div_act_d = div_act_q;
    acc_d     = acc_q;
    sr_d      = 1'b0;
    ph_d      = '0;
    slot_p_d  = 1'b0;
    idx_d     = idx_q;
    frac_d    = 1'b0;

    if (cen) begin
      base_d = base_end ? 3'd0 : base_q + 3'd1;
      if (base_end) begin
        slot_d = (slot_q == SLOT_LAST) ? 6'd0 : slot_q + 6'd1;
      end
      if (frame_end) begin
        div_act_d = ss;
      end

      sr_d     = base_zero && (slot_q == 6'd0);
      slot_p_d = base_zero && ({1'b0, slot_q} < ACTIVE_W);
      for (int k = 0; k < PHASES; k++) begin
        ph_d[k] = base_zero && (slot_q == 6'(k * ACTIVE / PHASES));
      end
      if (base_zero) begin
        idx_d = slot_q;
      end

      if (acc_sum >= FD_W) begin
        acc_d  = acc_sum - FD_W;
        frac_d = 1'b1;
      end else begin
        acc_d  = acc_sum;
      end

`ifdef JT6295_CENGEN_SYNC_EN
      // The restart changes the next state only. The pulses above still
      // come from the counters as they were before the restart.
      if (sync) begin
        base_d    = 3'd0;
        slot_d    = 6'd0;
        div_act_d = ss;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= 3'd0;
      slot_q    <= 6'd0;
      div_act_q <= ss;
      acc_q     <= '0;
      sr_q      <= 1'b0;
      ph_q      <= '0;
      slot_p_q  <= 1'b0;
      idx_q     <= 6'd0;
      frac_q    <= 1'b0;
    end else begin
      base_q    <= base_d;
      slot_q    <= slot_d;
      div_act_q <= div_act_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      ph_q      <= ph_d;
      slot_p_q  <= slot_p_d;
      idx_q     <= idx_d;
      frac_q    <= frac_d;
    end
  end

  assign cen_sr   = sr_q;
  assign cen_ph   = ph_q;
  assign cen_slot = slot_p_q;
  assign slot_idx = idx_q;
  assign cen_frac = frac_q;

endmodule

// File: tb/tb_jt6295_cengen.sv
// Directed bench for jt6295_cengen with the default parameters
// (DIV_LO=5, DIV_HI=4, SLOTS=33, ACTIVE=32, PHASES=4, FN=6, FD=125).
// The position of a tick inside the frame is p. For a divider d the slot is
// p/d and the base count is p%d. After the n-th cen since reset,
// cen_frac is expected exactly when (6*n) % 125 < 6.
module tb_jt6295_cengen;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       ss;
`ifdef JT6295_CENGEN_SYNC_EN
  logic       sync;
`endif
  logic       cen_sr;
  logic [3:0] cen_ph;
  logic       cen_slot;
  logic [5:0] slot_idx;
  logic       cen_frac;

  jt6295_cengen dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .ss       (ss),
`ifdef JT6295_CENGEN_SYNC_EN
    .sync     (sync),
`endif
    .cen_sr   (cen_sr),
    .cen_ph   (cen_ph),
    .cen_slot (cen_slot),
    .slot_idx (slot_idx),
    .cen_frac (cen_frac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         ncen;
  int         clk_n;
  logic [5:0] idx_exp;

  int frac_cnt, frac_first, frac_last, gap_min, gap_max, slot_cnt;
  int last_sr, ph0_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one clk with the given cen, then sample 1 ns after the edge.
  task automatic tick(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    clk_n++;
  endtask

  task automatic step(input logic c, input int d, input int p, input string tag);
    int         s;
    int         b;
    logic [3:0] ph_e;
    logic       sr_e, sl_e, fr_e;
    tick(c);
    s    = p / d;
    b    = p % d;
    sr_e = 1'b0;
    sl_e = 1'b0;
    fr_e = 1'b0;
    ph_e = 4'd0;
    if (c) begin
      ncen++;
      sr_e = (p == 0);
      sl_e = (b == 0) && (s < 32);
      for (int k = 0; k < 4; k++) ph_e[k] = (b == 0) && (s == 8 * k);
      if (b == 0) idx_exp = 6'(s);
      fr_e = ((6 * ncen) % 125) < 6;
    end
    chk(tag, {19'd0, cen_sr, cen_slot, cen_ph, slot_idx, cen_frac},
             {19'd0, sr_e, sl_e, ph_e, idx_exp, fr_e});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick(1'b1);
      chk("rst_outs", {19'd0, cen_sr, cen_slot, cen_ph, slot_idx, cen_frac}, 32'd0);
    end
    rst     = 1'b0;
    ncen    = 0;
    idx_exp = 6'd0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    ncen    = 0;
    clk_n   = 0;
    idx_exp = 6'd0;
    rst     = 1'b1;
    cen     = 1'b0;
    ss      = 1'b1;
`ifdef JT6295_CENGEN_SYNC_EN
    sync    = 1'b0;
`endif

    // A: DIV_HI, cen every clk; frame of 132, fractional rate over 1250 cen.
    do_reset(3);
    frac_cnt = 0; frac_first = 0; frac_last = 0;
    gap_min = 999; gap_max = 0; slot_cnt = 0;
    for (int t = 1; t <= 1250; t++) begin
      step(1'b1, 4, (t - 1) % 132, "A_seq");
      if (cen_frac) begin
        if (frac_cnt == 0) frac_first = t;
        else begin
          if (t - frac_last < gap_min) gap_min = t - frac_last;
          if (t - frac_last > gap_max) gap_max = t - frac_last;
        end
        frac_last = t;
        frac_cnt++;
      end
      if (t <= 132 && cen_slot) slot_cnt++;
    end
    chk("A_frac_cnt",   32'(frac_cnt),   32'd60);
    chk("A_frac_first", 32'(frac_first), 32'd21);
    chk("A_frac_gmin",  32'(gap_min),    32'd20);
    chk("A_frac_gmax",  32'(gap_max),    32'd21);
    chk("A_slot_cnt",   32'(slot_cnt),   32'd32);

    // B: DIV_LO, cen every second clk; sample period of 330 clk.
    ss = 1'b0;
    do_reset(2);
    clk_n = 0; last_sr = -1; ph0_clk = -1;
    for (int n = 1; n <= 331; n++) begin
      step(1'b1, 5, (n - 1) % 165, "B_on");
      if (cen_sr) begin
        if (last_sr >= 0) chk("B_sr_gap", 32'(clk_n - last_sr), 32'd330);
        last_sr = clk_n;
      end
      if (cen_ph[0] && ph0_clk < 0) ph0_clk = clk_n;
      if (cen_ph[1] && n < 165) chk("B_ph_gap", 32'(clk_n - ph0_clk), 32'd80);
      step(1'b0, 5, 0, "B_off");
    end

    // C: ss 1->0 at slot 10 of a DIV_HI frame; that frame stays 132 long.
    ss = 1'b1;
    do_reset(2);
    for (int t = 1; t <= 132; t++) begin
      step(1'b1, 4, t - 1, "C_fr1");
      if (t == 41) ss = 1'b0;
    end
    for (int t = 1; t <= 165; t++) step(1'b1, 5, t - 1, "C_fr2");
    // A brief ss pulse in mid-frame must not change the divider.
    for (int t = 1; t <= 86; t++) begin
      if (t == 20) ss = 1'b1;
      if (t == 30) ss = 1'b0;
      step(1'b1, 5, t - 1, "C_fr3");
    end

    // D: reset at slot 17, then restart cleanly from slot 0.
    do_reset(3);
    for (int t = 1; t <= 170; t++) step(1'b1, 5, (t - 1) % 165, "D_post");

`ifdef JT6295_CENGEN_SYNC_EN
    // E: sync at slot 20, base 2, restarts the frame; sync without cen is ignored.
    ss = 1'b1;
    do_reset(2);
    for (int t = 1; t <= 82; t++) step(1'b1, 4, t - 1, "E_pre");
    sync = 1'b1;
    step(1'b1, 4, 82, "E_sync");
    sync = 1'b0;
    for (int t = 1; t <= 134; t++) begin
      if (t == 50) begin
        sync = 1'b1;
        step(1'b0, 4, 0, "E_nocen");
        sync = 1'b0;
      end
      step(1'b1, 4, (t - 1) % 132, "E_post");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
